// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin burst arbiter: FSM state encoding
// and the width helper used to size the owner index and burst counter.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Bits needed to hold values 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: returns the first set bit of v_i searching
// upward from ptr_i and wrapping past N-1 back to 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = 4,
  localparam int ID_W = clog2(N)
) (
  input  logic [ID_W-1:0] ptr_i,
  input  logic [N-1:0]    v_i,
  output logic            found_o,
  output logic [ID_W-1:0] idx_o
);

  logic [N-1:0]  rot_s;
  logic [ID_W:0] pos_s;
  logic [ID_W:0] sum_s;
  logic [ID_W:0] off_s;

  // Rotate so ptr_i lands at bit 0, find the lowest set bit, rotate back.
  always_comb begin
    rot_s   = {N{1'b0}};
    pos_s   = {(ID_W+1){1'b0}};
    off_s   = {(ID_W+1){1'b0}};
    sum_s   = {(ID_W+1){1'b0}};
    found_o = 1'b0;
    idx_o   = {ID_W{1'b0}};

    for (int i = 0; i < N; i++) begin
      pos_s = {1'b0, ptr_i} + (ID_W+1)'(i);
      if (pos_s >= (ID_W+1)'(N)) begin
        pos_s = pos_s - (ID_W+1)'(N);
      end else begin
        pos_s = pos_s;
      end
      rot_s[i] = v_i[pos_s[ID_W-1:0]];
    end

    // Descending scan so the lowest set offset is the one that sticks.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        found_o = 1'b1;
        off_s   = (ID_W+1)'(i);
      end else begin
        off_s   = off_s;
      end
    end

    sum_s = {1'b0, ptr_i} + off_s;
    if (sum_s >= (ID_W+1)'(N)) begin
      sum_s = sum_s - (ID_W+1)'(N);
    end else begin
      sum_s = sum_s;
    end
    idx_o = sum_s[ID_W-1:0];
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter that holds each grant for a whole transaction (until
// done, request drop, or the burst cap) and hands off back-to-back.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 8,
  localparam int ID_W     = clog2(N),
  localparam int CNT_W    = clog2(MAX_BURST + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_i,
  input  logic            done_i,
  output logic [N-1:0]    grant_o,
  output logic            grant_vld_o,
  output logic [ID_W-1:0] grant_id_o
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            vld_q, vld_d;
  logic [ID_W-1:0] gid_q, gid_d;

  logic [ID_W-1:0] owner_nxt_s;
  logic [ID_W-1:0] pick_ptr_s;
  logic            pick_found_s;
  logic [ID_W-1:0] pick_idx_s;
  logic            rel_s;

  // Owner+1 with wrap; this is both the post-release pointer and the
  // search start for the back-to-back handoff.
  always_comb begin
    owner_nxt_s = {ID_W{1'b0}};
    if (owner_q == ID_W'(N - 1)) begin
      owner_nxt_s = {ID_W{1'b0}};
    end else begin
      owner_nxt_s = owner_q + ID_W'(1);
    end
  end

  // One picker serves both paths: idle uses ptr, a releasing grant uses owner+1.
  always_comb begin
    pick_ptr_s = ptr_q;
    if (state_q == ST_GRANT) begin
      pick_ptr_s = owner_nxt_s;
    end else begin
      pick_ptr_s = ptr_q;
    end
  end

  rr_pick #(.N(N)) u_pick (
    .ptr_i   (pick_ptr_s),
    .v_i     (req_i),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  // Next-state logic: grant selection, hold/count, release and handoff.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    vld_d   = vld_q;
    gid_d   = gid_q;
    rel_s   = done_i | ~req_i[owner_q] | (cnt_q == CNT_W'(MAX_BURST));

    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          owner_d = pick_idx_s;
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
          vld_d   = 1'b1;
          gid_d   = pick_idx_s;
          cnt_d   = CNT_W'(1);
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!rel_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ptr_d = owner_nxt_s;
          if (pick_found_s) begin
            owner_d = pick_idx_s;
            grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
            vld_d   = 1'b1;
            gid_d   = pick_idx_s;
            cnt_d   = CNT_W'(1);
            state_d = ST_GRANT;
          end else begin
            grant_d = {N{1'b0}};
            vld_d   = 1'b0;
            gid_d   = {ID_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        grant_d = {N{1'b0}};
        vld_d   = 1'b0;
        gid_d   = {ID_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= {ID_W{1'b0}};
      owner_q <= {ID_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      grant_q <= {N{1'b0}};
      vld_q   <= 1'b0;
      gid_q   <= {ID_W{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      vld_q   <= vld_d;
      gid_q   <= gid_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_vld_o = vld_q;
  assign grant_id_o  = gid_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: a behavioural model pushes the
// expected outputs each cycle and each scenario pops and compares them,
// alongside fixed expectations for the directed cases.
module tb_rr_burst_arbiter;

  localparam int N         = 4;
  localparam int MAX_BURST = 8;
  localparam int ID_W      = 2;

  typedef struct packed {
    logic [N-1:0]    g;
    logic            v;
    logic [ID_W-1:0] id;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    grant_o;
  logic            grant_vld_o;
  logic [ID_W-1:0] grant_id_o;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  int           m_state;
  int           m_ptr;
  int           m_owner;
  int           m_cnt;
  logic [N-1:0] m_grant;

  rr_burst_arbiter #(.N(N), .MAX_BURST(MAX_BURST)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .done_i      (done),
    .grant_o     (grant_o),
    .grant_vld_o (grant_vld_o),
    .grant_id_o  (grant_id_o)
  );

  always #5 clk = ~clk;

  function automatic int mpick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_grant = '0;
    sb_q.delete();
  endtask

  // Advance the model on the current inputs, queue its outputs, clock the DUT.
  task automatic tick();
    exp_t e;
    int   w;
    bit   rel;
    if (m_state == 0) begin
      w = mpick(m_ptr, req);
      if (w >= 0) begin
        m_owner = w; m_grant = 4'b0001 << w; m_cnt = 1; m_state = 1;
      end
    end else begin
      rel = done || !req[m_owner] || (m_cnt == MAX_BURST);
      if (!rel) begin
        m_cnt = m_cnt + 1;
      end else begin
        m_ptr = (m_owner + 1) % N;
        w = mpick(m_ptr, req);
        if (w >= 0) begin
          m_owner = w; m_grant = 4'b0001 << w; m_cnt = 1;
        end else begin
          m_grant = '0; m_state = 0;
        end
      end
    end
    e.g  = m_grant;
    e.v  = (m_grant != 4'b0000);
    e.id = e.v ? ID_W'(m_owner) : 2'b00;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got, exp;
    got = {grant_o, grant_vld_o, grant_id_o};
    tests_run++;
    if (got !== 7'b0000_0_00) begin
      tests_failed++;
      $display("FAIL reset_initial got=%b required=%b", got, 7'b0000_0_00);
    end
    req = 4'b0100; done = 1'b0;
    tick();
    got = {grant_o, grant_vld_o, grant_id_o}; exp = sb_q.pop_front();
    tests_run++;
    if (got !== exp || grant_o !== 4'b0100) begin
      tests_failed++;
      $display("FAIL reset_pregrant got=%b required=%b", got, exp);
    end
    rst = 1'b1;
    #2;
    got = {grant_o, grant_vld_o, grant_id_o};
    tests_run++;
    if (got !== 7'b0000_0_00) begin
      tests_failed++;
      $display("FAIL reset_async got=%b required=%b", got, 7'b0000_0_00);
    end
    model_reset();
    req = 4'b0000;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      got = {grant_o, grant_vld_o, grant_id_o}; exp = sb_q.pop_front();
      tests_run++;
      if (got !== exp || grant_vld_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle c=%0d got=%b required=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_rotation();
    exp_t         got, exp;
    logic [N-1:0] tbl [5];
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111; done = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      got = {grant_o, grant_vld_o, grant_id_o}; exp = sb_q.pop_front();
      tests_run++;
      if (got !== exp || grant_o !== tbl[c]) begin
        tests_failed++;
        $display("FAIL rotation c=%0d got=%b required=%b/%b", c, got, exp, tbl[c]);
      end
    end
    req = 4'b0000; done = 1'b0;
    tick();
    got = {grant_o, grant_vld_o, grant_id_o}; exp = sb_q.pop_front();
    tests_run++;
    if (got !== exp || grant_o !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rotation_idle got=%b required=%b", got, exp);
    end
  endtask

  task automatic test_burst_cap();
    exp_t         got, exp;
    logic [N-1:0] want;
    do_reset();
    req = 4'b0011; done = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      want = (c <= 8) ? 4'b0001 : ((c <= 16) ? 4'b0010 : 4'b0001);
      got = {grant_o, grant_vld_o, grant_id_o}; exp = sb_q.pop_front();
      tests_run++;
      if (got !== exp || grant_o !== want) begin
        tests_failed++;
        $display("FAIL burst_cap c=%0d got=%b required=%b/%b", c, got, exp, want);
      end
    end
    req = 4'b0000;
    tick();
    void'(sb_q.pop_front());
  endtask

  task automatic test_sole_regrant();
    exp_t got, exp;
    do_reset();
    req = 4'b0100; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      got = {grant_o, grant_vld_o, grant_id_o}; exp = sb_q.pop_front();
      tests_run++;
      if (got !== exp || got !== 7'b0100_1_10) begin
        tests_failed++;
        $display("FAIL sole_regrant c=%0d got=%b required=%b", c, got, exp);
      end
    end
    req = 4'b0000;
    tick();
    void'(sb_q.pop_front());
  endtask

  task automatic test_drop_skip();
    exp_t got, exp;
    exp_t want [3];
    logic [N-1:0] reqs [3];
    want = '{7'b0010_1_01, 7'b1000_1_11, 7'b0000_0_00};
    reqs = '{4'b1010, 4'b1000, 4'b0000};
    do_reset();
    done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req = reqs[c];
      tick();
      got = {grant_o, grant_vld_o, grant_id_o}; exp = sb_q.pop_front();
      tests_run++;
      if (got !== exp || got !== want[c]) begin
        tests_failed++;
        $display("FAIL drop_skip c=%0d got=%b required=%b/%b", c, got, exp, want[c]);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t got, exp;
    exp_t want [7];
    logic [N-1:0] reqs [7];
    logic         dns  [7];
    // owner 3; done+partial drop wraps to 0; idle; done in idle ignored x2;
    // req with done in idle grants normally; hold with done low.
    reqs = '{4'b1000, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
    dns  = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b0};
    want = '{7'b1000_1_11, 7'b0001_1_00, 7'b0000_0_00, 7'b0000_0_00,
             7'b0000_0_00, 7'b0010_1_01, 7'b0010_1_01};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req = reqs[c]; done = dns[c];
      tick();
      got = {grant_o, grant_vld_o, grant_id_o}; exp = sb_q.pop_front();
      tests_run++;
      if (got !== exp || got !== want[c]) begin
        tests_failed++;
        $display("FAIL simultaneous c=%0d got=%b required=%b/%b", c, got, exp, want[c]);
      end
    end
  endtask

  task automatic test_random();
    exp_t got, exp;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      tick();
      got = {grant_o, grant_vld_o, grant_id_o};
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL random c=%0d scoreboard empty", c);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp || $countones(grant_o) > 1) begin
          tests_failed++;
          $display("FAIL random c=%0d got=%b required=%b", c, got, exp);
        end
      end
    end
    done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    model_reset();
    #12;
    rst = 1'b0;
    test_reset();
    test_rotation();
    test_burst_cap();
    test_sole_regrant();
    test_drop_skip();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
Round-robin arbiter that shares one bus or resource slot among N requesters and holds each grant for a whole transaction. A grant lasts until the owner signals done, drops its request, or reaches a burst-length cap. On release, the next requester is granted back-to-back with no dead cycle. It sits between requester front-ends and the shared datapath and drives the datapath's select mux via grant_id.

Parameters:
N, 4, number of requesters (2..16)
MAX_BURST, 8, max consecutive cycles one grant may be held (1..255)
ID_W (localparam), clog2(N), width of grant_id
CNT_W (localparam), clog2(MAX_BURST+1), width of burst counter

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
req  in  N  per-requester request, level, held until served
done  in  1  current owner finished its transaction; sampled only in GRANT
grant  out  N  one-hot grant, registered; all-zero when idle
grant_vld  out  1  registered; equals |grant
grant_id  out  ID_W  binary index of the owner; valid only when grant_vld=1, otherwise 0

Behaviour:
- Reset (async, rst=1): grant=0, grant_vld=0, grant_id=0, ptr=0, owner=0, cnt=0, state=IDLE. Reset asserted mid-grant drops the grant immediately, with no completion.
- ptr: highest-priority index for the next selection. pick(ptr, v) = first i in ptr, ptr+1, ..., N-1, 0, ..., ptr-1 with v[i]=1.
- State IDLE:
  - if |req at the edge: owner<=pick(ptr,req), grant<=onehot(owner), cnt<=1, state<=GRANT.
  - Latency from req rising to grant is 1 clock.
  - Otherwise everything holds.
- State GRANT: rel = done | ~req[owner] | (cnt==MAX_BURST).
  - rel=0: cnt<=cnt+1; grant holds.
  - rel=1: ptr<=(owner+1) mod N, then w=pick((owner+1) mod N, req) using the same-cycle req.
  - If w exists: grant<=onehot(w), owner<=w, cnt<=1, stay in GRANT. This is a back-to-back handoff with zero idle cycles.
  - If none: grant<=0, state<=IDLE.
- Work-conserving: if the owner is the only requester and still has req high at release, it is re-granted (pick wraps to it) and cnt restarts at 1.
- done is ignored in IDLE. done together with ~req[owner] is a single release.
- grant is never multi-hot. Every edge has at most one grant change.
- Starvation bound: a requester holding req waits at most (N-1)*MAX_BURST cycles + 1.
- Requests from non-owners never preempt the owner.
- ptr wraps from N-1 to 0.

Decomposition:
- Shared package arb_pkg: state encoding (IDLE=0, GRANT=1) and the clog2 function for ID_W/CNT_W.
- One natural sub-module: rr_pick. Combinational, parameter N, inputs ptr and v, outputs found and idx. It does a rotate, find-first-set, then rotate-back.
- rr_pick is instantiated once and shared between the IDLE and release paths, with ptr muxed between ptr and owner+1.

Test Plan:
- Reset: assert rst mid-simulation with grant=0100 -> grant=0000, grant_vld=0, grant_id=0 immediately, without waiting for clk; after release with req=0000, outputs stay 0.
- Rotation: req=1111 held, done pulsed every GRANT cycle -> grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no idle gaps.
- Burst cap (MAX_BURST=8): req=0011 held, done=0 -> grant=0001 for exactly 8 cycles, then 0010 for 8, then 0001 again.
- Sole requester re-grant: req=0100 held, done=0 -> grant=0100 continuously, with cnt wrapping 1..8 and grant_vld never dropping.
- Request drop and ptr skip: owner 1 with req=1010; drop req[1] -> next edge grant=1000 (index 3). Then drop all req -> grant=0000, and state returns to IDLE.
- Simultaneous events: with owner 3 and ptr wrap, req=0111 and done=1 on the same cycle -> grant=0001 (wrap to 0). Asserting done while in IDLE has no effect.
